// File: rtl/sw_io_pkg.sv
// Shared types and helpers for the switch code-entry block: index sentinel,
// per-switch pending encoding, sequence FSM states, flag encodings.
package sw_io_pkg;

  localparam logic [3:0] IDX_NONE = 4'hF;

  typedef enum logic [1:0] {
    PEND_NONE = 2'b00,
    PEND_UP   = 2'b01,
    PEND_DN   = 2'b10
  } pend_t;

  typedef enum logic {
    ST_CAPTURE = 1'b0,
    ST_FULL    = 1'b1
  } state_t;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_DN   = 2'b01;
  localparam logic [1:0] FLAG_UP   = 2'b11;

  function automatic logic [3:0] popcount(input logic [15:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sw_edge_pend.sv
// One switch bit: level history, Up/Down edge detection and a pending event
// that the top-level scanner consumes.
module sw_edge_pend
  import sw_io_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       sw,
  input  logic       scan_clr,
  output logic [1:0] pend
);

  logic  sw_q_r;
  pend_t pend_r;
  pend_t pend_nx_s;
  logic  rise_s;
  logic  fall_s;

  assign rise_s = sw & ~sw_q_r;
  assign fall_s = ~sw & sw_q_r;

  // Next pending state: a fresh edge beats the scan clear; an opposite edge cancels a glitch
  always_comb begin
    pend_nx_s = pend_r;
    if (rise_s) begin
      if (!scan_clr && (pend_r == PEND_DN)) begin
        pend_nx_s = PEND_NONE;
      end else begin
        pend_nx_s = PEND_UP;
      end
    end else if (fall_s) begin
      if (!scan_clr && (pend_r == PEND_UP)) begin
        pend_nx_s = PEND_NONE;
      end else begin
        pend_nx_s = PEND_DN;
      end
    end else if (scan_clr) begin
      pend_nx_s = PEND_NONE;
    end else begin
      pend_nx_s = pend_r;
    end
  end

  // History and pending registers; history loads the live level at reset so held switches stay silent
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sw_q_r <= sw;
      pend_r <= PEND_NONE;
    end else begin
      sw_q_r <= sw;
      pend_r <= pend_nx_s;
    end
  end

  assign pend = pend_r;

endmodule

// File: rtl/sw_code_entry.sv
// Switch code entry: round-robin event scanner, Up counting with conflict
// detection, and digit capture into a sequence offered with valid/ack.
module sw_code_entry
  import sw_io_pkg::*;
#(
  parameter int N_SW   = 10,
  parameter int DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [N_SW-1:0]       SW,
  input  logic                  CLR,
  input  logic                  SEQ_ACK,
  output logic [1:0]            SW_CHANGE_FLAG,
  output logic [3:0]            WHICH_SW_CHANGE,
  output logic [3:0]            UP_COUNT,
  output logic [3:0]            UP_LAST,
  output logic [4*DIGITS-1:0]   SEQUENCE,
  output logic [3:0]            SEQ_LEN,
  output logic                  SEQ_VALID,
  output logic                  CONFLICT
);

  localparam logic [3:0]          LAST_IDX  = 4'(N_SW - 1);
  localparam logic [3:0]          N_SW_L    = 4'(N_SW);
  localparam logic [3:0]          DIGITS_L  = 4'(DIGITS);
  localparam logic [4*DIGITS-1:0] SEQ_EMPTY = {DIGITS{IDX_NONE}};

  logic [1:0]          pend_s [N_SW];
  pend_t               pend_k_s;
  logic [3:0]          k_r, k_nx_s;
  logic [1:0]          flag_r, flag_nx_s;
  logic [3:0]          which_r, which_nx_s;
  logic [3:0]          count_r, count_nx_s;
  logic [3:0]          last_r, last_nx_s;
  logic                conflict_r, conflict_nx_s;
  logic [4*DIGITS-1:0] seq_r, seq_nx_s;
  logic [3:0]          len_r, len_nx_s;
  logic                valid_r, valid_nx_s;
  logic                wr_digit_s;
  state_t              state_r, state_nx_s;

  generate
    for (genvar i = 0; i < N_SW; i++) begin : g_bit
      sw_edge_pend u_pend (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .sw       (SW[i]),
        .scan_clr (k_r == 4'(i)),
        .pend     (pend_s[i])
      );
    end
  endgenerate

  // Pending state of the bit under the scanner
  always_comb begin
    pend_k_s = PEND_NONE;
    for (int i = 0; i < N_SW; i++) begin
      pend_k_s = (k_r == 4'(i)) ? pend_t'(pend_s[i]) : pend_k_s;
    end
  end

  // Scanner step, event reporting and Up bookkeeping
  always_comb begin
    flag_nx_s     = FLAG_NONE;
    which_nx_s    = IDX_NONE;
    count_nx_s    = count_r;
    last_nx_s     = last_r;
    conflict_nx_s = 1'b0;
    wr_digit_s    = 1'b0;
    if (k_r >= LAST_IDX) begin
      k_nx_s = 4'd0;
    end else begin
      k_nx_s = k_r + 4'd1;
    end
    case (pend_k_s)
      PEND_UP: begin
        flag_nx_s  = FLAG_UP;
        which_nx_s = k_r;
        if (count_r >= N_SW_L) begin
          count_nx_s = count_r;
        end else begin
          count_nx_s = count_r + 4'd1;
        end
        if (count_r == 4'd0) begin
          last_nx_s  = k_r;
          wr_digit_s = 1'b1;
        end else begin
          last_nx_s     = IDX_NONE;
          conflict_nx_s = 1'b1;
        end
      end
      PEND_DN: begin
        flag_nx_s  = FLAG_DN;
        which_nx_s = k_r;
        last_nx_s  = IDX_NONE;
        if (count_r == 4'd0) begin
          count_nx_s = 4'd0;
        end else begin
          count_nx_s = count_r - 4'd1;
        end
      end
      default: begin
        flag_nx_s  = FLAG_NONE;
        which_nx_s = IDX_NONE;
      end
    endcase
  end

  // Sequence FSM: CLR beats a same-cycle digit; ACK only counts once the sequence is full
  always_comb begin
    state_nx_s = state_r;
    seq_nx_s   = seq_r;
    len_nx_s   = len_r;
    case (state_r)
      ST_CAPTURE: begin
        if (CLR) begin
          seq_nx_s = SEQ_EMPTY;
          len_nx_s = 4'd0;
        end else if (wr_digit_s) begin
          for (int n = 0; n < DIGITS; n++) begin
            seq_nx_s[4*n +: 4] = (len_r == 4'(n)) ? k_r : seq_r[4*n +: 4];
          end
          len_nx_s = len_r + 4'd1;
          if ((len_r + 4'd1) == DIGITS_L) begin
            state_nx_s = ST_FULL;
          end else begin
            state_nx_s = ST_CAPTURE;
          end
        end else begin
          state_nx_s = ST_CAPTURE;
        end
      end
      ST_FULL: begin
        if (CLR || SEQ_ACK) begin
          seq_nx_s   = SEQ_EMPTY;
          len_nx_s   = 4'd0;
          state_nx_s = ST_CAPTURE;
        end else begin
          state_nx_s = ST_FULL;
        end
      end
      default: begin
        seq_nx_s   = SEQ_EMPTY;
        len_nx_s   = 4'd0;
        state_nx_s = ST_CAPTURE;
      end
    endcase
    valid_nx_s = (state_nx_s == ST_FULL);
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r <= ST_CAPTURE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath and output registers; the Up count starts from switches already held
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      k_r        <= 4'd0;
      flag_r     <= FLAG_NONE;
      which_r    <= IDX_NONE;
      count_r    <= popcount(16'(SW));
      last_r     <= IDX_NONE;
      conflict_r <= 1'b0;
      seq_r      <= SEQ_EMPTY;
      len_r      <= 4'd0;
      valid_r    <= 1'b0;
    end else begin
      k_r        <= k_nx_s;
      flag_r     <= flag_nx_s;
      which_r    <= which_nx_s;
      count_r    <= count_nx_s;
      last_r     <= last_nx_s;
      conflict_r <= conflict_nx_s;
      seq_r      <= seq_nx_s;
      len_r      <= len_nx_s;
      valid_r    <= valid_nx_s;
    end
  end

  assign SW_CHANGE_FLAG  = flag_r;
  assign WHICH_SW_CHANGE = which_r;
  assign UP_COUNT        = count_r;
  assign UP_LAST         = last_r;
  assign SEQUENCE        = seq_r;
  assign SEQ_LEN         = len_r;
  assign SEQ_VALID       = valid_r;
  assign CONFLICT        = conflict_r;

endmodule

// File: tb/tb_sw_code_entry.sv
// Bench for sw_code_entry: a 10/4 and a 15/8 instance, each tracked by an
// event-level model checked every cycle, plus directed literal expectations.
module tb_sw_code_entry;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [9:0]  sw_a;
  logic [14:0] sw_b;
  logic        clr_a, ack_a, clr_b, ack_b;

  logic [1:0]  flag_a, flag_b;
  logic [3:0]  which_a, which_b, cnt_a, cnt_b, last_a, last_b, len_a, len_b;
  logic [15:0] seq_a;
  logic [31:0] seq_b;
  logic        valid_a, valid_b, conf_a, conf_b;

  always #5 CLK = ~CLK;

  sw_code_entry #(.N_SW(10), .DIGITS(4)) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .SW(sw_a), .CLR(clr_a), .SEQ_ACK(ack_a),
    .SW_CHANGE_FLAG(flag_a), .WHICH_SW_CHANGE(which_a), .UP_COUNT(cnt_a),
    .UP_LAST(last_a), .SEQUENCE(seq_a), .SEQ_LEN(len_a), .SEQ_VALID(valid_a),
    .CONFLICT(conf_a)
  );

  sw_code_entry #(.N_SW(15), .DIGITS(8)) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .SW(sw_b), .CLR(clr_b), .SEQ_ACK(ack_b),
    .SW_CHANGE_FLAG(flag_b), .WHICH_SW_CHANGE(which_b), .UP_COUNT(cnt_b),
    .UP_LAST(last_b), .SEQUENCE(seq_b), .SEQ_LEN(len_b), .SEQ_VALID(valid_b),
    .CONFLICT(conf_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Event-level model, one slot per instance
  int          nsw [2] = '{10, 15};
  int          nd  [2] = '{4, 8};
  logic [15:0] m_prev [2];
  int          m_pend [2][16];
  int          m_dig  [2][8];
  int          m_k [2], m_cnt [2], m_last [2], m_flag [2], m_which [2];
  int          m_conf [2], m_len [2], m_valid [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input logic [15:0] sw, input logic clr,
                            input logic ack, input logic rstn);
    int p, kk, d;
    bit take;
    if (!rstn) begin
      m_prev[i] = sw;
      for (int b = 0; b < 16; b++) m_pend[i][b] = 0;
      m_k[i] = 0; m_cnt[i] = $countones(sw); m_last[i] = 15;
      m_flag[i] = 0; m_which[i] = 15; m_conf[i] = 0;
      m_len[i] = 0; m_valid[i] = 0;
    end else begin
      kk = m_k[i];
      p = m_pend[i][kk];
      take = 1'b0;
      m_flag[i] = 0; m_which[i] = 15; m_conf[i] = 0;
      if (p == 1) begin
        m_flag[i] = 3; m_which[i] = kk;
        if (m_cnt[i] == 0) begin
          m_last[i] = kk; take = 1'b1;
        end else begin
          m_conf[i] = 1; m_last[i] = 15;
        end
        if (m_cnt[i] < nsw[i]) m_cnt[i]++;
      end else if (p == -1) begin
        m_flag[i] = 1; m_which[i] = kk; m_last[i] = 15;
        if (m_cnt[i] > 0) m_cnt[i]--;
      end
      if (clr) begin
        m_len[i] = 0; m_valid[i] = 0;
      end else if (m_valid[i] != 0) begin
        if (ack) begin m_len[i] = 0; m_valid[i] = 0; end
      end else if (take) begin
        m_dig[i][m_len[i]] = kk;
        m_len[i]++;
        if (m_len[i] == nd[i]) m_valid[i] = 1;
      end
      m_pend[i][kk] = 0;
      for (int b = 0; b < nsw[i]; b++) begin
        if (sw[b] !== m_prev[i][b]) begin
          d = sw[b] ? 1 : -1;
          m_pend[i][b] = (m_pend[i][b] == -d) ? 0 : d;
        end
      end
      m_prev[i] = sw;
      m_k[i] = (kk + 1) % nsw[i];
    end
  endtask

  function automatic logic [31:0] exp_seq(input int i);
    logic [31:0] s;
    s = 32'h0;
    for (int n = 0; n < nd[i]; n++) begin
      s[4*n +: 4] = (n < m_len[i]) ? 4'(m_dig[i][n]) : 4'hF;
    end
    return s;
  endfunction

  task automatic cmp_inst(input int i, input string nm, input logic [1:0] flag,
                          input logic [3:0] which, input logic [3:0] cnt, input logic [3:0] last,
                          input logic [31:0] seq, input logic [3:0] len, input logic valid,
                          input logic conf);
    check({nm, ".flag"},     32'(flag),  32'(m_flag[i]));
    check({nm, ".which"},    32'(which), 32'(m_which[i]));
    check({nm, ".up_count"}, 32'(cnt),   32'(m_cnt[i]));
    check({nm, ".up_last"},  32'(last),  32'(m_last[i]));
    check({nm, ".sequence"}, seq,        exp_seq(i));
    check({nm, ".seq_len"},  32'(len),   32'(m_len[i]));
    check({nm, ".seq_valid"},32'(valid), 32'(m_valid[i]));
    check({nm, ".conflict"}, 32'(conf),  32'(m_conf[i]));
  endtask

  // Per-cycle model update and comparison, 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge CLK);
      model_step(0, {6'b000000, sw_a}, clr_a, ack_a, RESET_N);
      model_step(1, {1'b0, sw_b}, clr_b, ack_b, RESET_N);
      #1;
      cmp_inst(0, "A", flag_a, which_a, cnt_a, last_a, {16'h0000, seq_a}, len_a, valid_a, conf_a);
      cmp_inst(1, "B", flag_b, which_b, cnt_b, last_b, seq_b, len_b, valid_b, conf_b);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_k(input int i, input int v);
    for (int t = 0; t < 20 && m_k[i] != v; t++) cyc(1);
    check("wait_scanner", 32'(m_k[i]), 32'(v));
  endtask

  int  pulses;
  bit  seen;
  int  digs_a [4] = '{3, 1, 4, 9};

  initial begin
    RESET_N = 1'b0;
    sw_a = 10'b0000000101; sw_b = 15'h0000;
    clr_a = 1'b0; ack_a = 1'b0; clr_b = 1'b0; ack_b = 1'b0;
    cyc(2);
    RESET_N = 1'b1;
    check("rst_up_count", 32'(cnt_a), 32'd2);
    check("rst_up_last", 32'(last_a), 32'hF);
    check("rst_seq", 32'(seq_a), 32'h0000FFFF);
    pulses = 0;
    for (int t = 0; t < 20; t++) begin
      cyc(1);
      if (flag_a[0]) pulses++;
    end
    check("rst_no_flags", 32'(pulses), 32'd0);

    sw_a = 10'b0000000000;
    cyc(12);
    check("all_down_count", 32'(cnt_a), 32'd0);

    foreach (digs_a[j]) begin
      sw_a[digs_a[j]] = 1'b1; cyc(12);
      sw_a[digs_a[j]] = 1'b0; cyc(12);
    end
    check("seq_9413", 32'(seq_a), 32'h00009413);
    check("seq_len_4", 32'(len_a), 32'd4);
    check("seq_valid_1", 32'(valid_a), 32'd1);
    ack_a = 1'b1; cyc(1); ack_a = 1'b0;
    check("ack_seq", 32'(seq_a), 32'h0000FFFF);
    check("ack_len", 32'(len_a), 32'd0);
    check("ack_valid", 32'(valid_a), 32'd0);

    // Conflict: SW[2] held, then SW[5]
    sw_a[2] = 1'b1; cyc(12);
    check("hold2_len", 32'(len_a), 32'd1);
    sw_a[5] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 12 && !seen; t++) begin
      cyc(1);
      if (flag_a == 2'b11 && which_a == 4'd5) begin
        seen = 1'b1;
        check("conf_pulse", 32'(conf_a), 32'd1);
        check("conf_count", 32'(cnt_a), 32'd2);
        check("conf_last", 32'(last_a), 32'hF);
        check("conf_len", 32'(len_a), 32'd1);
      end
    end
    check("conf_seen", 32'(seen), 32'd1);
    sw_a[2] = 1'b0; sw_a[5] = 1'b0; cyc(12);

    // One-cycle glitch on SW[7] well before the scanner arrives
    wait_k(0, 2);
    sw_a[7] = 1'b1; cyc(1); sw_a[7] = 1'b0;
    pulses = 0;
    for (int t = 0; t < 12; t++) begin
      cyc(1);
      if (flag_a[0] && which_a == 4'd7) pulses++;
    end
    check("glitch_no_flag", 32'(pulses), 32'd0);
    check("glitch_count", 32'(cnt_a), 32'd0);

    // Second digit, then CLR in the cycle the third is scanned
    sw_a[6] = 1'b1; cyc(12); sw_a[6] = 1'b0; cyc(12);
    check("two_digit_seq", 32'(seq_a), 32'h0000FF62);
    wait_k(0, 5);
    sw_a[8] = 1'b1; cyc(3);
    clr_a = 1'b1; cyc(1); clr_a = 1'b0;
    check("clr_flag", 32'(flag_a), 32'd3);
    check("clr_which", 32'(which_a), 32'd8);
    check("clr_len", 32'(len_a), 32'd0);
    check("clr_seq", 32'(seq_a), 32'h0000FFFF);
    sw_a[8] = 1'b0; cyc(12);

    // Wide build: eight digits fill the sequence
    for (int d = 1; d <= 8; d++) begin
      sw_b[d] = 1'b1; cyc(17);
      sw_b[d] = 1'b0; cyc(17);
    end
    check("b_valid", 32'(valid_b), 32'd1);
    check("b_seq", seq_b, 32'h87654321);
    check("b_len", 32'(len_b), 32'd8);
    sw_b[14] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 17 && !seen; t++) begin
      cyc(1);
      if (flag_b == 2'b11 && which_b == 4'd14) seen = 1'b1;
    end
    check("b_ninth_flag", 32'(seen), 32'd1);
    check("b_ninth_seq", seq_b, 32'h87654321);
    sw_b[14] = 1'b0; cyc(17);
    ack_b = 1'b1; cyc(1); ack_b = 1'b0;
    check("b_ack_seq", seq_b, 32'hFFFFFFFF);
    check("b_ack_valid", 32'(valid_b), 32'd0);
    sw_b[12] = 1'b1; cyc(17); sw_b[12] = 1'b0; cyc(17);
    check("b_one_digit", seq_b, 32'hFFFFFFFC);
    ack_b = 1'b1; cyc(1); ack_b = 1'b0; cyc(1);
    check("b_ack_ignored_len", 32'(len_b), 32'd1);
    check("b_ack_ignored_seq", seq_b, 32'hFFFFFFFC);

    // Reset mid-sequence discards the captured digit
    RESET_N = 1'b0; cyc(1); RESET_N = 1'b1;
    check("b_rst_len", 32'(len_b), 32'd0);
    check("b_rst_seq", seq_b, 32'hFFFFFFFF);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_code_entry.md
# sw_code_entry

Parametrised switch code-entry block: it samples `N_SW` slide switches, turns level changes into per-switch Up/Down events, and reports them through a round-robin scanner. Exclusive single-switch Up events are captured as decimal-index digits into a `DIGITS`-long sequence. A completed sequence is offered to the downstream user/admin code checker with a valid/ack handshake. It sits between the debounced switch inputs and the lock-control FSM, and generalises the fixed 10-switch/4-digit switch I/O block with width/depth parameters, internal history, conflict reporting and explicit clear/consume.

## Interface
- `N_SW`, 10, number of switches; legal range 2..15.
- `DIGITS`, 4, sequence depth in 4-bit digits; legal range 1..8.
- `CLK`  in  1  system clock; all state updates on rising edge.
- `RESET_N`  in  1  synchronous, active-low reset.
- `SW`  in  N_SW  switch levels, already synchronised and debounced upstream.
- `CLR`  in  1  abandon current sequence (level; acts every cycle asserted).
- `SEQ_ACK`  in  1  consumer has taken SEQUENCE; honoured only while SEQ_VALID=1.
- `SW_CHANGE_FLAG`  out  2  [0]=change reported this cycle, [1]=1 Up / 0 Down.
- `WHICH_SW_CHANGE`  out  4  index of reported switch; 4'hF when none.
- `UP_COUNT`  out  4  number of switches currently counted Up.
- `UP_LAST`  out  4  index of the single accepted Up switch; 4'hF when none or conflict.
- `SEQUENCE`  out  4*DIGITS  digit n at bits [4n+3:4n]; unused digits 4'hF.
- `SEQ_LEN`  out  4  digits captured, 0..DIGITS.
- `SEQ_VALID`  out  1  sequence complete, held until ACK/CLR.
- `CONFLICT`  out  1  one-cycle pulse: Up scanned while another switch already Up.

## Operation
- History: `sw_q` is registered from SW every cycle. Per bit: rise (SW=1, sw_q=0) → Up edge; fall → Down edge.
- Pending state per bit: NONE/UP/DN. An edge sets the bit's pending state to its direction. An opposite edge arriving while pending returns it to NONE (the glitch cancels). The scanner clears the pending state of bit `k` when it reports it. A new edge on that bit in the same cycle wins over the clear.
- Scanner `k` steps 0..N_SW-1 every cycle and wraps to 0. One bit is examined per cycle.
- Pending UP at k:
  - FLAG=2'b11, WHICH=k, UP_COUNT+1 (saturates at N_SW).
  - If old UP_COUNT==0: UP_LAST=k. If in CAPTURE, write digit k at position SEQ_LEN and increment SEQ_LEN.
  - If old UP_COUNT≥1: CONFLICT=1, UP_LAST=4'hF, no digit is written.
- Pending DN at k:
  - FLAG=2'b01, WHICH=k, UP_COUNT-1 (floor 0).
  - If new count==1, UP_LAST stays 4'hF (it is not reconstructed). If new count==0, UP_LAST=4'hF.
  - SEQUENCE is unaffected.
- No pending event at k: FLAG=2'b00, WHICH=4'hF.
- FSM, two states:
  - CAPTURE: SEQ_VALID=0. Go to FULL in the cycle the DIGITS-th digit is written, with SEQ_VALID=1 from the next cycle.
  - FULL: digits are ignored. Flags, UP_COUNT, UP_LAST and CONFLICT keep updating. SEQ_ACK=1 → SEQUENCE all-F, SEQ_LEN=0, return to CAPTURE.
- CLR in either state gives the same clear as ACK. CLR has priority over a digit write in the same cycle, so the digit is lost. SEQ_ACK in CAPTURE is ignored.
- Reset values:
  - `sw_q`←SW; all pending NONE; k=0.
  - UP_COUNT←popcount(SW); UP_LAST=4'hF.
  - FLAG=0, WHICH=4'hF, CONFLICT=0.
  - SEQUENCE all-F, SEQ_LEN=0, SEQ_VALID=0, state CAPTURE.
  - Switches already up at reset produce no events.

## Timing
- All outputs are registered.
- An edge on SW sampled at cycle t becomes pending at t+1.
- The event is reported on outputs between 1 and N_SW cycles later, depending on where k is.
- Worst-case event-to-digit latency is N_SW+1 cycles.
- FLAG and CONFLICT are single-cycle per event.
- SEQ_VALID rises the cycle after the final digit write and falls the cycle after ACK/CLR.
- Reset asserted mid-sequence discards all captured digits and pending events at the next edge.

## Structure
- Package `sw_io_pkg`:
  - `IDX_NONE`=4'hF
  - pending encoding (NONE/UP/DN)
  - FSM state typedef (CAPTURE/FULL)
  - FLAG encodings
  - `popcount` function
- Sub-module `sw_edge_pend`: one bit of history register, edge detect and pending state with scan-clear. Instantiated N_SW times by generate.
- The top level holds the scanner, counters, sequence register and FSM.

## Test plan
- Reset with SW=10'b0000000101 → UP_COUNT=2, UP_LAST=F, no FLAG pulses for 2*N_SW cycles.
- From all-down, raise and lower SW[3], SW[1], SW[4], SW[9] one at a time (each held > N_SW cycles) → SEQUENCE=16'h9413, SEQ_LEN=4, SEQ_VALID=1; SEQ_ACK → SEQUENCE=16'hFFFF, SEQ_LEN=0 next cycle.
- Hold SW[2] up, then raise SW[5] → FLAG=2'b11 with WHICH=5, CONFLICT pulse, UP_COUNT=2, UP_LAST=F, SEQ_LEN unchanged.
- Pulse SW[7] up for 1 cycle then back down before k reaches 7 → no FLAG pulse, UP_COUNT unchanged.
- With 2 digits captured, assert CLR in the same cycle a third digit is scanned → SEQ_LEN=0, SEQUENCE all-F.
- N_SW=15, DIGITS=8 build: enter 8 digits → SEQ_VALID; a ninth Up → FLAG pulse only, SEQUENCE unchanged; SEQ_ACK while SEQ_VALID=0 → no effect.
